stopwatch_bcd_counter: RTL and testbench



---
 rtl/stopwatch_bcd_counter.sv | 202 ++++++++++++++++++++
 tb/tb_stopwatch_bcd_counter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_bcd_counter.sv
// Four-digit BCD stopwatch (SS.hh, 00.00..59.99) in 10 ms steps with two raw push-buttons.
// Each button is synchronised, debounced and edge-detected locally before driving the run/pause/clear FSM.

module stopwatch_btn_cond #(
  parameter int DEB_CNT = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic prs
);

  localparam int CW = $clog2(DEB_CNT);

  logic          s1_q, s2_q;
  logic          deb_q, deb_d;
  logic          deb_prev_q;
  logic          prs_q, prs_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // deb only follows s2 after DEB_CNT consecutive disagreeing samples
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (s2_q != deb_q) begin
      if (cnt_q == CW'(DEB_CNT - 1)) begin
        deb_d = s2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    prs_d = deb_q & ~deb_prev_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      prs_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_q       <= btn;
      s2_q       <= s1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      prs_q      <= prs_d;
      cnt_q      <= cnt_d;
    end
  end

  assign prs = prs_q;

endmodule

module stopwatch_bcd_counter #(
  parameter int TICK_DIV = 1_000_000,
  parameter int DEB_CNT  = 500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_clr,
  output logic [3:0] dig3,
  output logic [3:0] dig2,
  output logic [3:0] dig1,
  output logic [3:0] dig0,
  output logic       running,
  output logic       wrap
);

  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    dig3_q, dig3_d;
  logic [3:0]    dig2_q, dig2_d;
  logic [3:0]    dig1_q, dig1_d;
  logic [3:0]    dig0_q, dig0_d;
  logic          running_q, running_d;
  logic          wrap_q, wrap_d;
  logic          prs_start, prs_clr;
  logic          tick;
  logic          at_max;

  stopwatch_btn_cond #(.DEB_CNT(DEB_CNT)) u_btn_start (
    .clk (clk),
    .rst (rst),
    .btn (btn_start),
    .prs (prs_start)
  );

  stopwatch_btn_cond #(.DEB_CNT(DEB_CNT)) u_btn_clr (
    .clk (clk),
    .rst (rst),
    .btn (btn_clr),
    .prs (prs_clr)
  );

  // Saturating-to-zero step keeps a digit inside 0..last even from a corrupt value
  function automatic logic [3:0] bcd_step(input logic [3:0] v, input logic [3:0] last);
    if (v >= last) begin
      return 4'd0;
    end
    return v + 4'd1;
  endfunction

  assign tick   = (state_q == S_RUN) && (presc_q == PW'(TICK_DIV - 1));
  assign at_max = (dig3_q == 4'd5) && (dig2_q == 4'd9) &&
                  (dig1_q == 4'd9) && (dig0_q == 4'd9);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (prs_start) state_d = S_RUN;
      S_RUN:   if (prs_start) state_d = S_PAUSE;
      S_PAUSE: if (prs_start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
    if (prs_clr) begin
      state_d = S_IDLE;
    end
    running_d = (state_d == S_RUN);
  end

  always_comb begin
    presc_d = presc_q;
    dig3_d  = dig3_q;
    dig2_d  = dig2_q;
    dig1_d  = dig1_q;
    dig0_d  = dig0_q;
    wrap_d  = 1'b0;

    case (state_q)
      S_RUN:   presc_d = tick ? '0 : presc_q + PW'(1);
      S_PAUSE: presc_d = presc_q;
      default: presc_d = '0;
    endcase

    // Ripple carry: a digit advances only when every lower digit wraps
    if (tick) begin
      dig0_d = bcd_step(dig0_q, 4'd9);
      if (dig0_q == 4'd9) begin
        dig1_d = bcd_step(dig1_q, 4'd9);
        if (dig1_q == 4'd9) begin
          dig2_d = bcd_step(dig2_q, 4'd9);
          if (dig2_q == 4'd9) begin
            dig3_d = bcd_step(dig3_q, 4'd5);
          end
        end
      end
      wrap_d = at_max;
    end

    if (prs_clr) begin
      presc_d = '0;
      dig3_d  = 4'd0;
      dig2_d  = 4'd0;
      dig1_d  = 4'd0;
      dig0_d  = 4'd0;
      wrap_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      dig3_q    <= 4'd0;
      dig2_q    <= 4'd0;
      dig1_q    <= 4'd0;
      dig0_q    <= 4'd0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      dig3_q    <= dig3_d;
      dig2_q    <= dig2_d;
      dig1_q    <= dig1_d;
      dig0_q    <= dig0_d;
      running_q <= running_d;
      wrap_q    <= wrap_d;
    end
  end

  assign dig3    = dig3_q;
  assign dig2    = dig2_q;
  assign dig1    = dig1_q;
  assign dig0    = dig0_q;
  assign running = running_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Bench for stopwatch_bcd_counter: elapsed time modelled as an integer count of hundredths,
// buttons modelled as sample histories, checked every cycle plus literal scenario checkpoints.

module tb_stopwatch_bcd_counter;

  localparam int TD = 4;
  localparam int DC = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_clr = 1'b0;
  logic [3:0] dig3, dig2, dig1, dig0;
  logic       running, wrap;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stopwatch_bcd_counter #(.TICK_DIV(TD), .DEB_CNT(DC)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_start (btn_start),
    .btn_clr   (btn_clr),
    .dig3      (dig3),
    .dig2      (dig2),
    .dig1      (dig1),
    .dig0      (dig0),
    .running   (running),
    .wrap      (wrap)
  );

  // Reference: state 0=idle 1=run 2=pause; time as hundredths 0..5999; button index 0=start 1=clr
  int m_count = 0;
  int m_presc = 0;
  int m_state = 0;
  bit m_wrap = 1'b0;
  bit m_s1[2], m_s2[2], m_deb[2], m_debp[2], m_prs[2];
  int m_run[2];

  initial begin
    bit tk, cl, st, raw;
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_debp[i] = 0; m_prs[i] = 0; m_run[i] = 0;
    end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_count = 0; m_presc = 0; m_state = 0; m_wrap = 0;
        for (int i = 0; i < 2; i++) begin
          m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_debp[i] = 0; m_prs[i] = 0; m_run[i] = 0;
        end
      end else begin
        tk = (m_state == 1) && (m_presc == TD - 1);
        st = m_prs[0];
        cl = m_prs[1];
        m_wrap = tk && (m_count == 5999) && !cl;
        if (cl) begin
          m_count = 0; m_presc = 0; m_state = 0;
        end else begin
          if (tk) m_count = (m_count + 1) % 6000;
          if (m_state == 1) m_presc = tk ? 0 : m_presc + 1;
          else if (m_state == 0) m_presc = 0;
          if (st) m_state = (m_state == 1) ? 2 : 1;
        end
        for (int i = 0; i < 2; i++) begin
          raw = (i == 0) ? btn_start : btn_clr;
          m_prs[i] = m_deb[i] && !m_debp[i];
          m_debp[i] = m_deb[i];
          if (m_s2[i] != m_deb[i]) begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] == DC) begin
              m_deb[i] = m_s2[i];
              m_run[i] = 0;
            end
          end else begin
            m_run[i] = 0;
          end
          m_s2[i] = m_s1[i];
          m_s1[i] = raw;
        end
      end
    end
  end

  // Per-cycle comparison on the falling edge
  initial begin
    int e3, e2, e1, e0;
    bit erun;
    forever begin
      @(negedge clk);
      e3 = m_count / 1000;
      e2 = (m_count / 100) % 10;
      e1 = (m_count / 10) % 10;
      e0 = m_count % 10;
      erun = (m_state == 1);
      n_cmp++;
      if (int'(dig3) != e3 || int'(dig2) != e2 || int'(dig1) != e1 || int'(dig0) != e0 ||
          running != erun || wrap != m_wrap) begin
        n_err++;
        $display("FAIL cycle t=%0t dut=%0d%0d.%0d%0d run=%0b wrap=%0b expected=%0d%0d.%0d%0d run=%0b wrap=%0b",
                 $time, dig3, dig2, dig1, dig0, running, wrap, e3, e2, e1, e0, erun, m_wrap);
      end
    end
  end

  function automatic int disp();
    return int'(dig3) * 1000 + int'(dig2) * 100 + int'(dig1) * 10 + int'(dig0);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns 1 ns after the first edge where the model shows count c (and prescaler p if p >= 0)
  task automatic wait_model(input string name, input int c, input int p, input int lim);
    for (int k = 0; k < lim; k++) begin
      @(posedge clk);
      #1;
      if (m_count == c && (p < 0 || m_presc == p)) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL %s timeout actual=none required=count %0d", name, c);
  endtask

  task automatic hold_start(input int n);
    btn_start = 1'b1;
    repeat (n) @(posedge clk);
    #2;
    btn_start = 1'b0;
  endtask

  initial begin
    // Reset and idle
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    cyc(5);
    check("reset_disp", disp(), 0);
    check("reset_running", running, 0);
    check("reset_wrap", wrap, 0);

    // Glitchy start button: 2-cycle pulses never survive debounce
    #1;
    for (int i = 0; i < 15; i++) begin
      btn_start = (i % 2 == 0);
      repeat (2) @(posedge clk);
      #2;
    end
    btn_start = 1'b0;
    cyc(20);
    check("glitch_running", running, 0);
    check("glitch_disp", disp(), 0);

    // Clean start: raised before edge k, running after edge k+6
    #1;
    btn_start = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("start_lat_k5", running, 0);
    @(posedge clk);
    #1;
    check("start_lat_k6", running, 1);
    check("start_disp0", disp(), 0);
    repeat (3) @(posedge clk);
    #2 btn_start = 1'b0;
    repeat (36) @(posedge clk);
    #1;
    check("start_k45", disp(), 9);
    @(posedge clk);
    #1;
    check("start_k46", disp(), 10);
    cyc(4);
    check("start_k50", disp(), 11);

    // Clear from RUN
    #1;
    btn_clr = 1'b1;
    cyc(7);
    check("clr_disp", disp(), 0);
    check("clr_running", running, 0);
    #1 btn_clr = 1'b0;
    cyc(10);

    // Pause at 00.03 with the prescaler two steps in, then resume
    #1;
    hold_start(7);
    wait_model("pause_wait", 1, 3, 100);
    #1;
    btn_start = 1'b1;
    cyc(6);
    check("pause_k5_running", running, 1);
    cyc(1);
    check("pause_running", running, 0);
    check("pause_disp", disp(), 3);
    check("model_pause_presc", m_presc, 2);
    #1 btn_start = 1'b0;
    cyc(100);
    check("pause_hold_disp", disp(), 3);
    #1;
    btn_start = 1'b1;
    cyc(7);
    check("resume_running", running, 1);
    check("resume_r6", disp(), 3);
    cyc(1);
    check("resume_r7", disp(), 3);
    cyc(1);
    check("resume_r8", disp(), 4);
    #1 btn_start = 1'b0;

    // Asynchronous reset mid-count at 12.34
    wait_model("rst_wait", 1234, -1, 6000);
    check("pre_rst_disp", disp(), 1234);
    check("pre_rst_running", running, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_disp", disp(), 0);
    check("async_rst_running", running, 0);
    check("async_rst_wrap", wrap, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    cyc(20);
    check("post_rst_disp", disp(), 0);
    check("post_rst_running", running, 0);

    // Rollover 59.99 -> 00.00
    #1;
    hold_start(7);
    wait_model("roll_wait", 5999, 3, 30000);
    check("roll_pre_disp", disp(), 5999);
    check("roll_pre_wrap", wrap, 0);
    cyc(1);
    check("roll_disp", disp(), 0);
    check("roll_wrap", wrap, 1);
    check("roll_running", running, 1);
    cyc(1);
    check("roll_wrap_low", wrap, 0);
    check("roll_running2", running, 1);
    check("roll_disp2", disp(), 0);

    // Start and clear presses coincide with the tick that would leave 07.50
    wait_model("prio_wait", 749, 1, 4000);
    #1;
    btn_start = 1'b1;
    btn_clr = 1'b1;
    cyc(6);
    check("prio_pre_disp", disp(), 750);
    check("model_prio_presc", m_presc, 3);
    check("prio_pre_running", running, 1);
    cyc(1);
    check("prio_disp", disp(), 0);
    check("prio_running", running, 0);
    check("prio_wrap", wrap, 0);
    check("model_prio_state", m_state, 0);
    #1;
    btn_start = 1'b0;
    btn_clr = 1'b0;
    cyc(20);
    check("prio_after_disp", disp(), 0);
    check("prio_after_running", running, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
